// File: rtl/bcd_updown_counter.sv
// Multi-decade BCD up/down counter with parallel load, clamped load values and boundary pulse.
// Define BCD_SATURATE_EN to hold at all-9s/all-0s instead of wrapping around.

module bcd_digit (
  input  logic [3:0] cur,
  input  logic       step,
  input  logic       up,
  output logic [3:0] nxt,
  output logic       is9,
  output logic       is0
);
  assign is9 = (cur == 4'd9);
  assign is0 = (cur == 4'd0);

  always_comb begin
    nxt = cur;
    if (step) begin
      if (up) nxt = is9 ? 4'd0 : cur + 4'd1;
      else    nxt = is0 ? 4'd9 : cur - 4'd1;
    end
  end
endmodule

module bcd_updown_counter #(
  parameter int DIGITS = 4,
  parameter int INIT   = 0
) (
  input  logic                  Clock,
  input  logic                  Clear,
  input  logic                  E,
  input  logic                  Up,
  input  logic                  Load,
  input  logic [4*DIGITS-1:0]   LoadVal,
  output logic [4*DIGITS-1:0]   BCD,
  output logic                  Wrap,
  output logic                  Max,
  output logic                  Zero
);
  localparam logic [3:0] INIT_NIB = 4'(INIT);

  logic [DIGITS-1:0][3:0] bcd_q, bcd_d, nxt;
  logic [DIGITS-1:0]      is9, is0, step;
  logic                   wrap_q, wrap_d;
  logic                   run9, run0, blocked;

  for (genvar g = 0; g < DIGITS; g++) begin : g_dig
    bcd_digit u_dig (
      .cur  (bcd_q[g]),
      .step (step[g]),
      .up   (Up),
      .nxt  (nxt[g]),
      .is9  (is9[g]),
      .is0  (is0[g])
    );
  end

  // A decade steps only when every lower decade sits at the carry/borrow value.
  always_comb begin
    step = '0;
    run9 = 1'b1;
    run0 = 1'b1;
    for (int k = 0; k < DIGITS; k++) begin
      step[k] = E & (Up ? run9 : run0);
      run9    = run9 & is9[k];
      run0    = run0 & is0[k];
    end
  end

  assign blocked = E & (Up ? (&is9) : (&is0));

  always_comb begin
    bcd_d  = nxt;
    wrap_d = blocked;
`ifdef BCD_SATURATE_EN
    if (blocked) bcd_d = bcd_q;
`endif
    if (Load) begin
      wrap_d = 1'b0;
      for (int k = 0; k < DIGITS; k++)
        bcd_d[k] = (LoadVal[4*k +: 4] > 4'd9) ? 4'd9 : LoadVal[4*k +: 4];
    end
  end

  always_ff @(posedge Clock) begin
    if (Clear) begin
      bcd_q  <= {DIGITS{INIT_NIB}};
      wrap_q <= 1'b0;
    end else begin
      bcd_q  <= bcd_d;
      wrap_q <= wrap_d;
    end
  end

  assign BCD  = bcd_q;
  assign Wrap = wrap_q;
  assign Max  = &is9;
  assign Zero = &is0;
endmodule

// File: tb/tb_bcd_updown_counter.sv
// Bench for bcd_updown_counter: directed vector table, hand sequences and a random run vs an integer model.
module tb_bcd_updown_counter;
`ifdef BCD_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        clr, e, up, ld;
  logic [15:0] lv;
  logic [15:0] bcd;
  logic        wrap, mx, zr;

  logic        clr1, e1, up1, ld1;
  logic [3:0]  lv1, bcd1;
  logic        wrap1, mx1, zr1;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  bcd_updown_counter #(.DIGITS(4), .INIT(0)) dut (
    .Clock(clk), .Clear(clr), .E(e), .Up(up), .Load(ld), .LoadVal(lv),
    .BCD(bcd), .Wrap(wrap), .Max(mx), .Zero(zr)
  );

  bcd_updown_counter #(.DIGITS(1), .INIT(5)) dut1 (
    .Clock(clk), .Clear(clr1), .E(e1), .Up(up1), .Load(ld1), .LoadVal(lv1),
    .BCD(bcd1), .Wrap(wrap1), .Max(mx1), .Zero(zr1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    int t;
    t = v;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  function automatic int load_int(input logic [15:0] x);
    int v, p, d;
    v = 0;
    p = 1;
    for (int i = 0; i < 4; i++) begin
      d = int'(x[4*i +: 4]);
      if (d > 9) d = 9;
      v += d * p;
      p *= 10;
    end
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    bit          clr, ld, e, up;
    logic [15:0] lv;
    logic [15:0] exp;
    bit          w;
  } vec_t;

  vec_t tbl[12];

  initial begin
    int m;
    bit wexp, wseen;

    clr = 0; e = 0; up = 0; ld = 0; lv = '0;
    clr1 = 0; e1 = 0; up1 = 0; ld1 = 0; lv1 = '0;

    tbl[0]  = '{1, 0, 0, 0, 16'h0000, 16'h0000, 0};
    tbl[1]  = '{0, 1, 0, 0, 16'h9998, 16'h9998, 0};
    tbl[2]  = '{0, 0, 1, 1, 16'h0000, 16'h9999, 0};
    tbl[3]  = '{0, 0, 1, 1, 16'h0000, SAT ? 16'h9999 : 16'h0000, 1};
    tbl[4]  = '{0, 0, 0, 1, 16'h0000, SAT ? 16'h9999 : 16'h0000, 0};
    tbl[5]  = '{0, 1, 0, 0, 16'h1000, 16'h1000, 0};
    tbl[6]  = '{0, 0, 1, 0, 16'h0000, 16'h0999, 0};
    tbl[7]  = '{0, 1, 0, 0, 16'h0000, 16'h0000, 0};
    tbl[8]  = '{0, 0, 1, 0, 16'h0000, SAT ? 16'h0000 : 16'h9999, 1};
    tbl[9]  = '{0, 1, 0, 0, 16'hF3A7, 16'h9397, 0};
    tbl[10] = '{1, 1, 1, 1, 16'h1234, 16'h0000, 0};
    tbl[11] = '{0, 1, 1, 1, 16'h0042, 16'h0042, 0};

    // Clear then ten increments: 0x0010, no Wrap pulse
    clr = 1; tick();
    chk("reset_bcd", 32'(bcd), 32'h0);
    chk("reset_wrap", 32'(wrap), 32'h0);
    chk("reset_zero", 32'(zr), 32'h1);
    clr = 0; e = 1; up = 1;
    wseen = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (wrap) wseen = 1;
    end
    chk("count10_bcd", 32'(bcd), 32'h0010);
    chk("count10_nowrap", 32'(wseen), 32'h0);
    e = 0;

    for (int i = 0; i < 12; i++) begin
      clr = tbl[i].clr; ld = tbl[i].ld; e = tbl[i].e; up = tbl[i].up; lv = tbl[i].lv;
      tick();
      chk($sformatf("vec%0d_bcd", i), 32'(bcd), 32'(tbl[i].exp));
      chk($sformatf("vec%0d_wrap", i), 32'(wrap), 32'(tbl[i].w));
      chk($sformatf("vec%0d_max", i), 32'(mx), 32'(tbl[i].exp == 16'h9999));
      chk($sformatf("vec%0d_zero", i), 32'(zr), 32'(tbl[i].exp == 16'h0000));
    end

    // Wrap is a one-cycle pulse: load 9999, step up, then idle
    clr = 0; ld = 1; e = 0; lv = 16'h9999; tick();
    ld = 0; e = 1; up = 1; tick();
    chk("pulse_on", 32'(wrap), 32'h1);
    e = 0; tick();
    chk("pulse_off", 32'(wrap), 32'h0);
    chk("pulse_hold", 32'(bcd), SAT ? 32'h9999 : 32'h0000);

    // Clear mid-count, then resume from INIT
    ld = 1; lv = 16'h0899; tick();
    ld = 0; e = 1; up = 1; clr = 1; tick();
    chk("midclr_bcd", 32'(bcd), 32'h0);
    clr = 0; tick();
    chk("midclr_resume", 32'(bcd), 32'h0001);

    // Single decade, INIT=5
    clr1 = 1; tick();
    chk("d1_reset", 32'(bcd1), 32'h5);
    clr1 = 0; e1 = 1; up1 = 1;
    for (int i = 1; i <= 5; i++) begin
      tick();
      chk($sformatf("d1_step%0d_bcd", i), 32'(bcd1), (i == 5) ? (SAT ? 32'h9 : 32'h0) : 32'(5 + i));
      chk($sformatf("d1_step%0d_wrap", i), 32'(wrap1), 32'(i == 5));
    end
    e1 = 0; ld1 = 1; lv1 = 4'hC; tick();
    chk("d1_clamp", 32'(bcd1), 32'h9);
    ld1 = 0;

    // Random run against an integer model of the count
    clr = 1; ld = 0; e = 0; tick();
    m = 0;
    clr = 0;
    for (int i = 0; i < 400; i++) begin
      clr = ($urandom_range(0, 29) == 0);
      ld  = ($urandom_range(0, 7) == 0);
      e   = ($urandom_range(0, 3) != 0);
      up  = $urandom_range(0, 1);
      case ($urandom_range(0, 3))
        0: lv = 16'h9999 - 16'($urandom_range(0, 2));
        1: lv = 16'($urandom_range(0, 2));
        default: lv = 16'($urandom);
      endcase
      wexp = 0;
      if (clr) m = 0;
      else if (ld) m = load_int(lv);
      else if (e) begin
        if (up) begin
          if (m == 9999) begin wexp = 1; if (!SAT) m = 0; end
          else m = m + 1;
        end else begin
          if (m == 0) begin wexp = 1; if (!SAT) m = 9999; end
          else m = m - 1;
        end
      end
      tick();
      chk($sformatf("rnd%0d_bcd", i), 32'(bcd), 32'(to_bcd(m)));
      chk($sformatf("rnd%0d_wrap", i), 32'(wrap), 32'(wexp));
      chk($sformatf("rnd%0d_max", i), 32'(mx), 32'(m == 9999));
      chk($sformatf("rnd%0d_zero", i), 32'(zr), 32'(m == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
